// File: rtl/usb_rx_line_decoder.sv
// Purpose : USB full-speed receive line front end: pin synchronizer, edge detect,
//           SE0 detect, NRZI decode and bit-stuff tracking.
// Latency : pins -> o_d_edge/o_eop 2 cycles; strobe -> o_d_orig/o_bit_stuff/o_stuff_err 1 cycle.
// Backpressure: none; the bit timer paces decoding through i_shift_en.
//
// Ports:
//   i_clk        system clock, all state on rising edge
//   i_rst        synchronous active-high reset
//   i_d_plus     raw asynchronous D+ pin
//   i_d_minus    raw asynchronous D- pin
//   i_rcving     high while the receive controller is inside a packet
//   i_shift_en   one-cycle bit-sample strobe from the bit timer
//   o_d_edge     one-cycle pulse on any transition of synchronized D+
//   o_d_orig     current NRZI-decoded bit, valid the cycle after a strobe
//   o_bit_stuff  high while the next strobe samples a stuffed bit
//   o_stuff_err  one-cycle pulse: the stuffed bit was not a 0
//   o_eop        high while synchronized D+ and D- are both 0 (SE0)

module usb_rx_line_decoder #(
    parameter int STUFF_LEN = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d_plus,
    input  logic i_d_minus,
    input  logic i_rcving,
    input  logic i_shift_en,
    output logic o_d_edge,
    output logic o_d_orig,
    output logic o_bit_stuff,
    output logic o_stuff_err,
    output logic o_eop
);

    localparam int CNT_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0] STUFF_MAX = CNT_W'(STUFF_LEN);

    // Synchronizer stages; reset to the idle J state (D+ high, D- low).
    logic r_dp1, r_dp2, r_dp3;
    logic r_dm1, r_dm2;

    // Decoder state.
    logic             r_prev_bit;
    logic             r_d_orig;
    logic             r_stuff_err;
    logic [CNT_W-1:0] r_ones_cnt;

    logic w_eop;
    logic w_dec_bit;
    logic w_bit_stuff;
    logic w_take_bit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dp1 <= 1'b1;
            r_dp2 <= 1'b1;
            r_dp3 <= 1'b1;
            r_dm1 <= 1'b0;
            r_dm2 <= 1'b0;
        end else begin
            r_dp1 <= i_d_plus;
            r_dp2 <= r_dp1;
            r_dp3 <= r_dp2;
            r_dm1 <= i_d_minus;
            r_dm2 <= r_dm1;
        end
    end

    // Line state is taken from the second synchronizer stage; the third D+
    // stage exists only to see a change of the synchronized value.
    assign w_eop       = ~r_dp2 & ~r_dm2;
    assign w_dec_bit   = (r_dp2 == r_prev_bit);   // no transition decodes as 1
    assign w_bit_stuff = (r_ones_cnt == STUFF_MAX);
    assign w_take_bit  = i_shift_en & i_rcving;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_bit  <= 1'b1;
            r_d_orig    <= 1'b1;
            r_stuff_err <= 1'b0;
            r_ones_cnt  <= '0;
        end else begin
            r_stuff_err <= 1'b0;
            if (!i_rcving) begin
                // Between packets the decoder re-arms to idle J; d_orig keeps
                // whatever it last presented.
                r_ones_cnt <= '0;
                r_prev_bit <= 1'b1;
            end else if (w_take_bit) begin
                if (w_eop) begin
                    // SE0 is not a data bit: restart decoding from J.
                    r_ones_cnt <= '0;
                    r_prev_bit <= 1'b1;
                    r_d_orig   <= 1'b1;
                end else begin
                    r_d_orig   <= w_dec_bit;
                    r_prev_bit <= r_dp2;
                    if (w_bit_stuff) begin
                        // This strobe carries the stuffed bit; it must be a 0.
                        r_ones_cnt  <= '0;
                        r_stuff_err <= w_dec_bit;
                    end else if (w_dec_bit) begin
                        r_ones_cnt <= r_ones_cnt + 1'b1;
                    end else begin
                        r_ones_cnt <= '0;
                    end
                end
            end
        end
    end

    assign o_d_edge    = r_dp2 ^ r_dp3;
    assign o_d_orig    = r_d_orig;
    assign o_bit_stuff = w_bit_stuff;
    assign o_stuff_err = r_stuff_err;
    assign o_eop       = w_eop;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
module tb_usb_rx_line_decoder;

    logic i_clk = 1'b0;
    logic i_rst, i_d_plus, i_d_minus, i_rcving, i_shift_en;
    logic o_d_edge, o_d_orig, o_bit_stuff, o_stuff_err, o_eop;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    usb_rx_line_decoder #(.STUFF_LEN(6)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_d_plus    (i_d_plus),
        .i_d_minus   (i_d_minus),
        .i_rcving    (i_rcving),
        .i_shift_en  (i_shift_en),
        .o_d_edge    (o_d_edge),
        .o_d_orig    (o_d_orig),
        .o_bit_stuff (o_bit_stuff),
        .o_stuff_err (o_stuff_err),
        .o_eop       (o_eop)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic line(input logic dp, input logic dm);
        i_d_plus  = dp;
        i_d_minus = dm;
    endtask

    // Put a line state on the pins, let it through the synchronizer, then strobe.
    task automatic send_bit(input logic dp, input logic dm);
        line(dp, dm);
        tick();
        tick();
        i_shift_en = 1'b1;
        tick();
        i_shift_en = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_rcving = 1'b0; i_shift_en = 1'b0;
        line(1'b0, 1'b1);                     // K on the pins during reset

        // 1. reset
        @(posedge i_clk); #1;
        tick();
        i_rst = 1'b0;
        tick();
        chk_eq("rst_d_edge", o_d_edge, 1'b0);
        chk_eq("rst_d_orig", o_d_orig, 1'b1);
        chk_eq("rst_bit_stuff", o_bit_stuff, 1'b0);
        chk_eq("rst_stuff_err", o_stuff_err, 1'b0);
        chk_eq("rst_eop", o_eop, 1'b0);
        tick();
        chk_eq("rst_edge_pulse", o_d_edge, 1'b1);
        tick();
        chk_eq("rst_edge_end", o_d_edge, 1'b0);

        // back to idle J
        line(1'b1, 1'b0);
        repeat (4) tick();

        // 2. edge latency
        i_rcving = 1'b1;
        line(1'b0, 1'b1);
        tick();
        chk_eq("edge_k", o_d_edge, 1'b0);
        tick();
        chk_eq("edge_k1", o_d_edge, 1'b1);
        tick();
        chk_eq("edge_k2", o_d_edge, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("edge_held", o_d_edge, 1'b0);
        end

        // 3. NRZI: K,K,J,J from prev J -> 0,1,0,1
        send_bit(1'b0, 1'b1); chk_eq("nrzi_0", o_d_orig, 1'b0);
        send_bit(1'b0, 1'b1); chk_eq("nrzi_1", o_d_orig, 1'b1);
        send_bit(1'b1, 1'b0); chk_eq("nrzi_2", o_d_orig, 1'b0);
        send_bit(1'b1, 1'b0); chk_eq("nrzi_3", o_d_orig, 1'b1);
        chk_eq("nrzi_cnt", dut.r_ones_cnt, 1);
        tick(); tick();
        chk_eq("nrzi_hold", o_d_orig, 1'b1);

        // 4. bit stuff, valid stuffed 0
        i_rcving = 1'b0; tick(); i_rcving = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            send_bit(1'b1, 1'b0);
            chk_eq("stuff_cnt", dut.r_ones_cnt, i);
            chk_eq("stuff_flag", o_bit_stuff, (i == 6) ? 1'b1 : 1'b0);
        end
        send_bit(1'b0, 1'b1);
        chk_eq("stuff_ok_err", o_stuff_err, 1'b0);
        chk_eq("stuff_ok_flag", o_bit_stuff, 1'b0);
        chk_eq("stuff_ok_cnt", dut.r_ones_cnt, 0);
        chk_eq("stuff_ok_dorig", o_d_orig, 1'b0);

        // 5. stuff error: seven constant K bits (prev is K)
        for (int i = 1; i <= 6; i++) send_bit(1'b0, 1'b1);
        chk_eq("serr_flag6", o_bit_stuff, 1'b1);
        chk_eq("serr_pre", o_stuff_err, 1'b0);
        send_bit(1'b0, 1'b1);
        chk_eq("serr_pulse", o_stuff_err, 1'b1);
        chk_eq("serr_flag", o_bit_stuff, 1'b0);
        chk_eq("serr_cnt", dut.r_ones_cnt, 0);
        tick();
        chk_eq("serr_end", o_stuff_err, 1'b0);

        // 6. EOP
        send_bit(1'b1, 1'b0); chk_eq("eop_pre0", o_d_orig, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk_eq("eop_pre_cnt", dut.r_ones_cnt, 2);
        line(1'b0, 1'b0);
        tick();
        chk_eq("eop_lat1", o_eop, 1'b0);
        tick();
        chk_eq("eop_lat2", o_eop, 1'b1);
        for (int i = 0; i < 2; i++) begin
            i_shift_en = 1'b1; tick(); i_shift_en = 1'b0;
            chk_eq("eop_dorig", o_d_orig, 1'b1);
            chk_eq("eop_cnt", dut.r_ones_cnt, 0);
            chk_eq("eop_serr", o_stuff_err, 1'b0);
            chk_eq("eop_level", o_eop, 1'b1);
            tick();
        end
        send_bit(1'b1, 1'b0);                 // J after SE0: prev restarted at J
        chk_eq("eop_after_dorig", o_d_orig, 1'b1);
        chk_eq("eop_after_eop", o_eop, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        chk_eq("drop_pre_cnt", dut.r_ones_cnt, 4);
        i_rcving = 1'b0;
        tick();
        chk_eq("drop_cnt", dut.r_ones_cnt, 0);
        chk_eq("drop_flag", o_bit_stuff, 1'b0);
        chk_eq("drop_dorig", o_d_orig, 1'b1);
        send_bit(1'b0, 1'b1);                 // strobe ignored while idle
        chk_eq("idle_strobe_dorig", o_d_orig, 1'b1);
        chk_eq("idle_strobe_cnt", dut.r_ones_cnt, 0);

        // edge and strobe in the same cycle: decode sees new dp2
        line(1'b1, 1'b0); repeat (3) tick();
        i_rcving = 1'b1;
        line(1'b0, 1'b1);
        tick(); tick();
        chk_eq("coinc_edge", o_d_edge, 1'b1);
        i_shift_en = 1'b1; tick(); i_shift_en = 1'b0;
        chk_eq("coinc_dorig", o_d_orig, 1'b0);

        // reset mid-packet with K on the pins
        send_bit(1'b0, 1'b1);
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        chk_eq("mid_rst_edge", o_d_edge, 1'b0);
        chk_eq("mid_rst_dorig", o_d_orig, 1'b1);
        chk_eq("mid_rst_cnt", dut.r_ones_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
